// File: rtl/monopix_readout_model_if.sv
// rtl/monopix_readout_model_if.sv - readout handshake and configuration bus of the pixel matrix model
//
// Purpose: bundles the FREEZE/READ/TOKEN/OUT column-drain handshake and the
// serial configuration lines between readout firmware (master) and matrix (slave).
// Signals:
//   FREEZE    master->slave  block new leading edges
//   READ      master->slave  rising edge requests one hit word
//   TOKEN     slave->master  some pixel holds a hit
//   OUT       slave->master  27-bit hit word, MSB first
//   SI_CONF   master->slave  configuration serial in
//   CLK_CONF  master->slave  configuration shift enable
//   LD_CONF   master->slave  load shift register into enable mask
//   DEF_CONF  master->slave  restore default mask (all enabled)
//   SO_CONF   slave->master  configuration serial out
interface monopix_readout_model_if;
  logic FREEZE;
  logic READ;
  logic TOKEN;
  logic OUT;
  logic SI_CONF;
  logic CLK_CONF;
  logic LD_CONF;
  logic DEF_CONF;
  logic SO_CONF;

  modport master (
    output FREEZE, READ, SI_CONF, CLK_CONF, LD_CONF, DEF_CONF,
    input  TOKEN, OUT, SO_CONF
  );

  modport slave (
    input  FREEZE, READ, SI_CONF, CLK_CONF, LD_CONF, DEF_CONF,
    output TOKEN, OUT, SO_CONF
  );
endinterface

// File: rtl/monopix_readout_model.sv
// rtl/monopix_readout_model.sv - reduced TJ-Monopix pixel matrix with column-drain readout
//
// Purpose: every pixel timestamps the leading and trailing edge of a hit with
// a 6-bit BCID and holds it until a READ drains it as a serial 27-bit word
// {col[5:0], row[8:0], LE[5:0], TE[5:0]}. A serial configuration register
// provides a per-pixel enable mask.
// Ports:
//   CLK_BX      single clock, all logic on the rising edge
//   RST_N       asynchronous active-low reset
//   RESET_BCID  synchronous clear of the BCID counter
//   ANA_HIT     discriminator outputs, bit p = col*NROW + row
//   PULSE       injection, ORed into every pixel's hit input
//   bus         readout handshake and configuration lines (slave side)
module monopix_readout_model #(
  parameter int NCOL = 4,
  parameter int NROW = 4
) (
  input  logic                 CLK_BX,
  input  logic                 RST_N,
  input  logic                 RESET_BCID,
  input  logic [NCOL*NROW-1:0] ANA_HIT,
  input  logic                 PULSE,
  monopix_readout_model_if.slave bus
);
  localparam int NPIX = NCOL * NROW;

  typedef enum logic [1:0] {
    PIX_IDLE,
    PIX_HIGH,
    PIX_PENDING
  } pix_state_t;

  logic [5:0]      bcid;
  logic [NPIX-1:0] hit;
  logic [NPIX-1:0] hit_d;
  logic [NPIX-1:0] pend;
  logic [NPIX-1:0] cfg_sr;
  logic [NPIX-1:0] mask;

  pix_state_t pix_state     [NPIX];
  pix_state_t pix_state_nxt [NPIX];
  logic [5:0] le            [NPIX];
  logic [5:0] le_nxt        [NPIX];
  logic [5:0] te            [NPIX];
  logic [5:0] te_nxt        [NPIX];

  logic        token;
  logic        read_d;
  logic        read_edge;
  logic        ser_busy;
  logic        take;
  logic [26:0] ser_word;
  logic [4:0]  ser_cnt;

  logic        found;
  logic [15:0] sel_pix;
  logic [5:0]  sel_col;
  logic [8:0]  sel_row;
  logic [5:0]  sel_le;
  logic [5:0]  sel_te;

  assign hit       = (ANA_HIT | {NPIX{PULSE}}) & mask;
  assign read_edge = bus.READ & ~read_d;
  assign ser_busy  = (ser_cnt != 5'd0);
  // A READ edge always starts a 27-bit word, even with nothing pending.
  assign take      = read_edge & ~ser_busy;

  assign bus.TOKEN   = token;
  assign bus.OUT     = ser_busy & ser_word[26];
  assign bus.SO_CONF = cfg_sr[NPIX-1];

  always_comb begin
    pend = '0;
    for (int p = 0; p < NPIX; p++) begin
      pend[p] = (pix_state[p] == PIX_PENDING);
    end
  end

  // Lowest pending index wins: scan downwards so the last match is the lowest.
  always_comb begin
    found   = 1'b0;
    sel_pix = '0;
    sel_col = '0;
    sel_row = '0;
    sel_le  = '0;
    sel_te  = '0;
    for (int c = NCOL - 1; c >= 0; c--) begin
      for (int r = NROW - 1; r >= 0; r--) begin
        if (pend[c*NROW + r]) begin
          found   = 1'b1;
          sel_pix = 16'(c*NROW + r);
          sel_col = 6'(c);
          sel_row = 9'(r);
          sel_le  = le[c*NROW + r];
          sel_te  = te[c*NROW + r];
        end
      end
    end
  end

  // Per-pixel next state. Edges seen in HIGH or PENDING are dropped; FREEZE
  // only masks leading edges so a running hit always completes.
  always_comb begin
    for (int p = 0; p < NPIX; p++) begin
      pix_state_nxt[p] = pix_state[p];
      le_nxt[p]        = le[p];
      te_nxt[p]        = te[p];
      case (pix_state[p])
        PIX_IDLE: begin
          if (hit[p] && !hit_d[p] && !bus.FREEZE) begin
            pix_state_nxt[p] = PIX_HIGH;
            le_nxt[p]        = bcid;
          end
        end
        PIX_HIGH: begin
          if (!hit[p]) begin
            pix_state_nxt[p] = PIX_PENDING;
            te_nxt[p]        = bcid;
          end
        end
        PIX_PENDING: begin
          if (take && found && (sel_pix == 16'(p))) begin
            pix_state_nxt[p] = PIX_IDLE;
          end
        end
        default: pix_state_nxt[p] = PIX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      for (int p = 0; p < NPIX; p++) begin
        pix_state[p] <= PIX_IDLE;
        le[p]        <= '0;
        te[p]        <= '0;
      end
    end else begin
      for (int p = 0; p < NPIX; p++) begin
        pix_state[p] <= pix_state_nxt[p];
        le[p]        <= le_nxt[p];
        te[p]        <= te_nxt[p];
      end
    end
  end

  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      bcid   <= '0;
      hit_d  <= '0;
      token  <= 1'b0;
      read_d <= 1'b0;
    end else begin
      bcid   <= RESET_BCID ? 6'd0 : bcid + 6'd1;
      hit_d  <= hit;
      token  <= |pend;
      read_d <= bus.READ;
    end
  end

  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      ser_word <= '0;
      ser_cnt  <= '0;
    end else if (take) begin
      ser_word <= found ? {sel_col, sel_row, sel_le, sel_te} : 27'd0;
      ser_cnt  <= 5'd27;
    end else if (ser_busy) begin
      ser_word <= {ser_word[25:0], 1'b0};
      ser_cnt  <= ser_cnt - 5'd1;
    end
  end

  // Load samples the pre-shift register when shift and load coincide.
  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      cfg_sr <= '0;
      mask   <= '1;
    end else begin
      if (bus.CLK_CONF) begin
        cfg_sr <= NPIX'({cfg_sr, bus.SI_CONF});
      end
      if (bus.DEF_CONF) begin
        mask <= '1;
      end else if (bus.LD_CONF) begin
        mask <= cfg_sr;
      end
    end
  end
endmodule

// File: tb/tb_monopix_readout_model.sv
// tb/tb_monopix_readout_model.sv - self-checking bench for monopix_readout_model
module tb_monopix_readout_model;
  localparam int NROW_TB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reset_bcid;
  logic [15:0] ana_hit;
  logic        pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_bcid = 0;
  logic [26:0] exp_q[$];

  monopix_readout_model_if bus ();

  monopix_readout_model #(.NCOL(4), .NROW(4)) dut (
    .CLK_BX     (clk),
    .RST_N      (rst_n),
    .RESET_BCID (reset_bcid),
    .ANA_HIT    (ana_hit),
    .PULSE      (pulse),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The bench keeps its own notion of the bunch counter for the coming cycle.
  task automatic tick();
    if (!rst_n || reset_bcid) tb_bcid = 0;
    else tb_bcid = (tb_bcid + 1) % 64;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] exp_word(input int p, input int le, input int te);
    return {6'(p / NROW_TB), 9'(p % NROW_TB), 6'(le % 64), 6'(te % 64)};
  endfunction

  task automatic queue_hits(input logic [15:0] pix, input int le, input int te);
    for (int p = 0; p < 16; p++)
      if (pix[p]) exp_q.push_back(exp_word(p, le, te));
  endtask

  task automatic hit_burst(input logic [15:0] pix, input bit use_pulse, input int dur,
                           output int le, output int te);
    le = tb_bcid;
    if (use_pulse) pulse = 1'b1;
    else ana_hit = pix;
    repeat (dur) tick();
    te = tb_bcid;
    ana_hit = '0;
    pulse = 1'b0;
    tick();
  endtask

  task automatic read_word(input bit busy_poke, output logic [26:0] w);
    bus.READ = 1'b1;
    tick();
    bus.READ = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      w[i] = bus.OUT;
      if (busy_poke && i == 13) bus.READ = 1'b1;
      if (busy_poke && i == 12) bus.READ = 1'b0;
      tick();
    end
    check("out_idle_after_word", 32'(bus.OUT), 32'd0);
  endtask

  task automatic drain(input string tag);
    logic [26:0] w;
    while (exp_q.size() > 0) begin
      read_word(1'b0, w);
      check(tag, 32'(w), 32'(exp_q.pop_front()));
    end
    read_word(1'b0, w);
    check({tag, "_empty_word"}, 32'(w), 32'd0);
    check({tag, "_token_low"}, 32'(bus.TOKEN), 32'd0);
  endtask

  task automatic shift_conf(input logic [15:0] v);
    for (int j = 15; j >= 0; j--) begin
      bus.SI_CONF  = v[j];
      bus.CLK_CONF = 1'b1;
      tick();
    end
    bus.CLK_CONF = 1'b0;
    bus.SI_CONF  = 1'b0;
  endtask

  initial begin
    logic [26:0] w;
    logic [15:0] pix;
    logic [15:0] q;
    int le;
    int te;
    int dur;
    bit seen;

    rst_n = 1'b0; reset_bcid = 1'b0; ana_hit = '0; pulse = 1'b0;
    bus.FREEZE = 1'b0; bus.READ = 1'b0; bus.SI_CONF = 1'b0;
    bus.CLK_CONF = 1'b0; bus.LD_CONF = 1'b0; bus.DEF_CONF = 1'b0;
    tick(); tick();
    check("reset_token", 32'(bus.TOKEN), 32'd0);
    check("reset_out", 32'(bus.OUT), 32'd0);
    check("reset_so_conf", 32'(bus.SO_CONF), 32'd0);
    rst_n = 1'b1;
    tb_bcid = 0;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (bus.TOKEN !== 1'b0) seen = 1'b1;
    end
    check("idle_token_100", 32'(seen), 32'd0);

    // single hit on pixel 5 from BCID 3 for 4 cycles
    reset_bcid = 1'b1; tick(); reset_bcid = 1'b0;
    tick(); tick(); tick();
    hit_burst(16'h0020, 1'b0, 4, le, te);
    tick(); tick();
    check("single_token", 32'(bus.TOKEN), 32'd1);
    bus.FREEZE = 1'b1;
    read_word(1'b0, w);
    check("single_word", 32'(w), 32'({6'd1, 9'd1, 6'd3, 6'd7}));
    tick();
    check("single_token_clear", 32'(bus.TOKEN), 32'd0);
    bus.FREEZE = 1'b0;

    // priority between pixels 9 and 2
    hit_burst(16'h0204, 1'b0, 3, le, te);
    tick(); tick();
    queue_hits(16'h0204, le, te);
    check("prio_first_is_pix2", 32'(exp_q[0]), 32'(exp_word(2, le, te)));
    drain("prio");

    // freeze blocks leading edges, including one that outlives the freeze
    bus.FREEZE = 1'b1;
    hit_burst(16'h0001, 1'b0, 2, le, te);
    tick(); tick(); tick();
    check("freeze_no_token", 32'(bus.TOKEN), 32'd0);
    ana_hit = 16'h0001; tick();
    bus.FREEZE = 1'b0; tick(); tick();
    ana_hit = '0; tick(); tick(); tick();
    check("freeze_lost_edge", 32'(bus.TOKEN), 32'd0);
    hit_burst(16'h0001, 1'b0, 2, le, te);
    tick(); tick();
    check("unfreeze_token", 32'(bus.TOKEN), 32'd1);
    queue_hits(16'h0001, le, te);
    drain("unfreeze");

    // randomized simultaneous hits
    for (int it = 0; it < 8; it++) begin
      pix = 16'($urandom_range(1, 65535));
      dur = int'($urandom_range(1, 9));
      repeat ($urandom_range(0, 5)) tick();
      hit_burst(pix, 1'b0, dur, le, te);
      tick(); tick();
      queue_hits(pix, le, te);
      drain("rand_hits");
    end

    // configuration: echo on SO_CONF and mask with pixel 3 disabled
    q = 16'($urandom);
    shift_conf(q);
    pix = 16'hFFF7;
    for (int i = 0; i < 16; i++) begin
      check("so_conf_echo", 32'(bus.SO_CONF), 32'(q[15-i]));
      bus.SI_CONF  = pix[15-i];
      bus.CLK_CONF = 1'b1;
      tick();
    end
    bus.CLK_CONF = 1'b0;
    bus.LD_CONF = 1'b1; tick(); bus.LD_CONF = 1'b0;
    hit_burst(16'h0000, 1'b1, 2, le, te);
    tick(); tick();
    queue_hits(16'hFFF7, le, te);
    drain("mask_pix3_off");

    bus.DEF_CONF = 1'b1; tick(); bus.DEF_CONF = 1'b0;
    hit_burst(16'h0000, 1'b1, 2, le, te);
    tick(); tick();
    queue_hits(16'hFFFF, le, te);
    drain("mask_default");

    pix = 16'($urandom_range(1, 65535));
    shift_conf(pix);
    bus.LD_CONF = 1'b1; tick(); bus.LD_CONF = 1'b0;
    hit_burst(16'h0000, 1'b1, 3, le, te);
    tick(); tick();
    queue_hits(pix, le, te);
    drain("mask_random");
    bus.DEF_CONF = 1'b1; tick(); bus.DEF_CONF = 1'b0;

    // BCID wrap and READ ignored while busy
    while (tb_bcid != 62) tick();
    hit_burst(16'h0840, 1'b0, 4, le, te);
    tick(); tick();
    read_word(1'b1, w);
    check("wrap_word_pix6", 32'(w), 32'(exp_word(6, 62, 2)));
    read_word(1'b0, w);
    check("wrap_word_pix11", 32'(w), 32'(exp_word(11, 62, 2)));
    read_word(1'b0, w);
    check("wrap_empty_word", 32'(w), 32'd0);

    // reset in the middle of a word, then the mask is back to all enabled
    hit_burst(16'h0002, 1'b0, 2, le, te);
    tick(); tick();
    bus.READ = 1'b1; tick(); bus.READ = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midread_reset_out", 32'(bus.OUT), 32'd0);
    check("midread_reset_token", 32'(bus.TOKEN), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_out", 32'(bus.OUT), 32'd0);
    read_word(1'b0, w);
    check("post_reset_word_discarded", 32'(w), 32'd0);
    hit_burst(16'h0000, 1'b1, 2, le, te);
    tick(); tick();
    queue_hits(16'hFFFF, le, te);
    drain("post_reset_mask");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
